cdb_wb_arbiter: RTL and testbench
=================================

# cdb_wb_arbiter

Write-back arbiter for the out-of-order core's common data bus (CDB). It accepts completed results (write-enable, destination register, ROB/RS tag, 32-bit data) from three execution sources: ALU0, ALU1 and the load unit. It buffers each source in a small FIFO and broadcasts up to two results per cycle on two registered CDB ports to the register file, the reservation stations and the ROB. A round-robin scheduler shares the two ports fairly, and per-source ready backpressure stalls a producer whose buffer is full.

## Interface
Parameters:
- DW, 32, result data width
- RW, 5, destination register index width
- TW, 5, tag width
- DEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash (mispredict recovery)
- src_valid  in  3  per-source result valid; bit0 = ALU0, bit1 = ALU1, bit2 = load unit
- src_ready  out  3  per-source FIFO not full
- src_dst  in  3*RW  per-source destination; source s occupies [s*RW +: RW]
- src_tag  in  3*TW  per-source tag, same packing
- src_data  in  3*DW  per-source data, same packing
- cdb0_we, cdb1_we  out  1  port broadcast valid
- cdb0_dst, cdb1_dst  out  RW  destination register
- cdb0_tag, cdb1_tag  out  TW  producer tag
- cdb0_data, cdb1_data  out  DW  result

## Operation
- Push: source s is written into FIFO s when src_valid[s] & src_ready[s].
- src_ready[s] = (count[s] < DEPTH). It is driven from registered count only. A pop in the same cycle does not raise ready (no full bypass).
- Arbitration runs every cycle over FIFO heads as registered at the start of the cycle. There is no empty bypass: an entry pushed at edge k is first eligible in the cycle after edge k.
- Search order: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first non-empty FIFO goes to port 0 and the second to port 1. The third waits.
  - At most one pop per FIFO per cycle.
- rr_ptr ← (index of last granted source + 1) mod 3 when at least one grant is made; otherwise unchanged.
- Output registers:
  - On each edge, cdbN_we ← grantN.
  - When grantN is set, dst/tag/data are loaded from the granted head.
  - When grantN is clear, dst/tag/data hold their previous values.
- Results with dst = 0 are broadcast normally; zero-register suppression is the consumer's job.
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged.
- flush (synchronous, highest priority):
  - On the edge with flush=1, all FIFO counts and read/write pointers go to 0 and both cdbN_we go to 0.
  - Pushes and grants in that cycle are discarded.
  - rr_ptr is unchanged.
  - src_ready is all-ones the cycle after.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Timing
- Reset (async assert, all state cleared immediately):
  - FIFO counts, pointers and rr_ptr = 0.
  - cdb0/1_we = 0; dst, tag, data = 0.
  - src_ready = 3'b111.
- Latency: src_valid sampled at edge E0 → earliest cdb broadcast visible after edge E1 (2 edges).
- Throughput: 2 results/cycle sustained. With three sources saturated, each source gets 2 grants every 3 cycles.
- Reset deassertion mid-traffic: the first push can be accepted on the first edge after deassertion.
- Outputs are pure flops. There is no combinational path from src_* to cdb*. src_ready depends only on state.

## Test plan
- Reset:
  - Drive traffic, then assert rst asynchronously between edges.
  - Required: all cdb outputs 0 immediately, src_ready = 3'b111.
  - After release, one ALU0 result (dst=3, tag=7, data=0xDEADBEEF) appears on cdb0 exactly 2 edges after acceptance; cdb1_we stays 0.
- Single source burst:
  - ALU1 holds src_valid for 6 cycles.
  - Required: ready drops only when count=2, one cdb grant per cycle, data order preserved, no drops or duplicates.
- Contention:
  - All three sources valid every cycle, starting with rr_ptr=0.
  - Required grant pairs: (0,1), (2,0), (1,2), repeating.
  - Over 30 cycles each source is granted exactly 20 times.
- Backpressure boundary:
  - Fill the load FIFO to DEPTH while it is not granted.
  - Required: src_ready[2]=0.
  - In a cycle with a pop and a new valid, the push is not accepted. Ready returns the next cycle and no entry is lost.
- Flush:
  - With 2 entries buffered per source, assert flush for one cycle together with new pushes.
  - Required: both cdb_we = 0 after that edge, no flushed or same-cycle-pushed entry is ever broadcast, and src_ready = 3'b111 in the next cycle.
- Wrap-around: stream 100 random results per source with random valid/ready gaps. The scoreboard checks per-source ordering and exact tag/data match across pointer wraps.

Source files
------------

// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter: three per-source result FIFOs, round-robin onto two registered CDB ports
module cdb_wb_arbiter #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int TW = 5,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [2:0]      src_valid,
    output logic [2:0]      src_ready,
    input  logic [3*RW-1:0] src_dst,
    input  logic [3*TW-1:0] src_tag,
    input  logic [3*DW-1:0] src_data,
    output logic            cdb0_we,
    output logic [RW-1:0]   cdb0_dst,
    output logic [TW-1:0]   cdb0_tag,
    output logic [DW-1:0]   cdb0_data,
    output logic            cdb1_we,
    output logic [RW-1:0]   cdb1_dst,
    output logic [TW-1:0]   cdb1_tag,
    output logic [DW-1:0]   cdb1_data
);
    localparam int EW = RW + TW + DW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [EW-1:0] mem [3][DEPTH];
    logic [AW-1:0] rd_ptr [3];
    logic [AW-1:0] wr_ptr [3];
    logic [CW-1:0] count [3];
    logic [1:0]    rr_ptr;
    logic [2:0]    ne, push, pop;
    logic [1:0]    o0, o1, o2, sel0, sel1, last;
    logic          g0, g1;

    // ready and occupancy come straight from registered counts, so no src_* to cdb* path exists
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            src_ready[s] = count[s] < CW'(DEPTH);
            ne[s]        = count[s] != '0;
            push[s]      = src_valid[s] & src_ready[s];
        end
    end

    // pick the first two non-empty heads in rotating order starting at rr_ptr
    always_comb begin
        o0   = rr_ptr;
        o1   = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
        o2   = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
        g0   = |ne;
        sel0 = ne[o0] ? o0 : (ne[o1] ? o1 : o2);
        g1   = ne[o0] ? (ne[o1] | ne[o2]) : (ne[o1] & ne[o2]);
        sel1 = (ne[o0] & ne[o1]) ? o1 : o2;
        last = g1 ? sel1 : sel0;
        pop  = (g0 ? (3'b001 << sel0) : 3'b000) | (g1 ? (3'b001 << sel1) : 3'b000);
    end

    // FIFO payload storage; stale slots are harmless because pointers gate visibility
    always_ff @(posedge clk) begin
        for (int s = 0; s < 3; s++)
            if (push[s])
                mem[s][wr_ptr[s]] <= {src_dst[s*RW +: RW], src_tag[s*TW +: TW], src_data[s*DW +: DW]};
    end

    // FIFO pointers and counts; flush empties every buffer and drops same-cycle pushes and pops
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int s = 0; s < 3; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + AW'(1);
                if (pop[s]) rd_ptr[s] <= rd_ptr[s] + AW'(1);
                count[s] <= count[s] + CW'(push[s]) - CW'(pop[s]);
            end
        end
    end

    // advance the round-robin pointer past the last granted source; flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 2'd0;
        else if (!flush && g0)
            rr_ptr <= (last == 2'd2) ? 2'd0 : last + 2'd1;
    end

    // registered CDB ports: valid follows the grant, payload holds when not granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb0_we <= 1'b0;
            cdb1_we <= 1'b0;
            {cdb0_dst, cdb0_tag, cdb0_data} <= '0;
            {cdb1_dst, cdb1_tag, cdb1_data} <= '0;
        end else if (flush) begin
            cdb0_we <= 1'b0;
            cdb1_we <= 1'b0;
        end else begin
            cdb0_we <= g0;
            cdb1_we <= g1;
            if (g0) {cdb0_dst, cdb0_tag, cdb0_data} <= mem[sel0][rd_ptr[sel0]];
            if (g1) {cdb1_dst, cdb1_tag, cdb1_data} <= mem[sel1][rd_ptr[sel1]];
        end
    end
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// tb_cdb_wb_arbiter: queue-based reference model feeding a per-cycle scoreboard for the CDB arbiter
module tb_cdb_wb_arbiter;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 5;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [RW-1:0] dst;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct packed {
        logic       we0;
        ent_t       e0;
        logic       we1;
        ent_t       e1;
        logic [2:0] rdy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      src_valid = '0;
    logic [2:0]      src_ready;
    logic [3*RW-1:0] src_dst = '0;
    logic [3*TW-1:0] src_tag = '0;
    logic [3*DW-1:0] src_data = '0;
    logic            cdb0_we, cdb1_we;
    logic [RW-1:0]   cdb0_dst, cdb1_dst;
    logic [TW-1:0]   cdb0_tag, cdb1_tag;
    logic [DW-1:0]   cdb0_data, cdb1_data;

    cdb_wb_arbiter #(.DW(DW), .RW(RW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_dst(src_dst), .src_tag(src_tag), .src_data(src_data),
        .cdb0_we(cdb0_we), .cdb0_dst(cdb0_dst), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_we(cdb1_we), .cdb1_dst(cdb1_dst), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_chk = 0;
    exp_t exp_q[$];
    ent_t mq[3][$];
    exp_t cur;
    exp_t rst_exp;
    int   rr = 0;
    int   acc[3];
    int   seq[3];
    int   m_pre[3];
    int   m_ng, m_last, m_s;
    ent_t m_e;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    function automatic exp_t act_now();
        return {cdb0_we, cdb0_dst, cdb0_tag, cdb0_data, cdb1_we, cdb1_dst, cdb1_tag, cdb1_data, src_ready};
    endfunction

    initial begin
        rst_exp = '0;
        rst_exp.rdy = 3'b111;
    end

    // reference model: per-source queues, rotating first-two-non-empty selection
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 3; s++) begin
                mq[s].delete();
                acc[s] = 0;
            end
            rr = 0;
            exp_q.delete();
            cur = rst_exp;
        end else begin
            for (int s = 0; s < 3; s++) m_pre[s] = mq[s].size();
            cur.we0 = 1'b0;
            cur.we1 = 1'b0;
            if (flush) begin
                for (int s = 0; s < 3; s++) mq[s].delete();
            end else begin
                m_ng = 0;
                m_last = 0;
                for (int k = 0; k < 3; k++) begin
                    m_s = (rr + k) % 3;
                    if (m_pre[m_s] > 0 && m_ng < 2) begin
                        m_e = mq[m_s].pop_front();
                        if (m_ng == 0) begin
                            cur.we0 = 1'b1;
                            cur.e0 = m_e;
                        end else begin
                            cur.we1 = 1'b1;
                            cur.e1 = m_e;
                        end
                        m_ng++;
                        m_last = m_s;
                    end
                end
                if (m_ng > 0) rr = (m_last + 1) % 3;
                for (int s = 0; s < 3; s++) begin
                    if (src_valid[s] && m_pre[s] < DEPTH) begin
                        m_e.dst = src_dst[s*RW +: RW];
                        m_e.tag = src_tag[s*TW +: TW];
                        m_e.data = src_data[s*DW +: DW];
                        mq[s].push_back(m_e);
                        acc[s]++;
                    end
                end
            end
            for (int s = 0; s < 3; s++) cur.rdy[s] = mq[s].size() < DEPTH;
            exp_q.push_back(cur);
        end
    end

    // monitor: every cycle compares all ports against the oldest expected state
    always @(negedge clk) begin
        exp_t me;
        if (rst) begin
            chk("reset_state", 128'(act_now()), 128'(rst_exp));
        end else if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 128'(1), 128'(0));
        end else begin
            me = exp_q.pop_front();
            chk("cdb_cycle", 128'(act_now()), 128'(me));
        end
    end

    task automatic cyc(input logic [2:0] v, input logic f);
        @(negedge clk);
        #1;
        src_valid = v;
        flush = f;
        for (int s = 0; s < 3; s++) begin
            src_dst[s*RW +: RW] = RW'($urandom);
            src_tag[s*TW +: TW] = {2'(s), 3'(seq[s])};
            src_data[s*DW +: DW] = $urandom;
            seq[s]++;
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        #1;
        rst = 1'b1;
        src_valid = '0;
        flush = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         gc[3];
        int         guard;
        logic [2:0] v;
        logic [3:0] pairs[3];
        pairs[0] = 4'b0001;
        pairs[1] = 4'b1000;
        pairs[2] = 4'b0110;
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;

        // traffic then asynchronous reset between edges
        repeat (4) cyc(3'b111, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", 128'(act_now()), 128'(rst_exp));
        @(negedge clk);
        #1;
        rst = 1'b0;
        src_valid = 3'b001;
        src_dst[RW-1:0] = 5'd3;
        src_tag[TW-1:0] = 5'd7;
        src_data[DW-1:0] = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        chk("lat_e0", 128'(cdb0_we), 128'(0));
        src_valid = '0;
        @(posedge clk);
        #1;
        chk("lat_e1", 128'({cdb0_we, cdb0_dst, cdb0_tag, cdb0_data, cdb1_we}),
            128'({1'b1, 5'd3, 5'd7, 32'hDEADBEEF, 1'b0}));

        // single-source burst on ALU1
        repeat (6) cyc(3'b010, 1'b0);
        repeat (4) cyc(3'b000, 1'b0);

        // full contention from rr_ptr = 0
        do_rst();
        for (int s = 0; s < 3; s++) gc[s] = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(3'b111, 1'b0);
            if (i >= 2) begin
                chk("rr_pair", 128'({cdb0_we, cdb1_we, cdb0_tag[4:3], cdb1_tag[4:3]}),
                    128'({2'b11, pairs[(i-2)%3]}));
                if (cdb0_we) gc[cdb0_tag[4:3]]++;
                if (cdb1_we) gc[cdb1_tag[4:3]]++;
            end
        end
        for (int s = 0; s < 3; s++) chk("share_20", 128'(gc[s]), 128'(20));

        // backpressure on the load unit FIFO
        do_rst();
        cyc(3'b111, 1'b0);
        cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b0);
        chk("bp_full", 128'(src_ready[2]), 128'(0));
        cyc(3'b000, 1'b0);
        chk("bp_ready_back", 128'({src_ready[2], cdb0_we, cdb0_tag[4:3]}), 128'({1'b1, 1'b1, 2'd2}));
        repeat (4) cyc(3'b000, 1'b0);

        // flush with buffered entries and same-cycle pushes
        do_rst();
        repeat (3) cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b1);
        cyc(3'b000, 1'b0);
        chk("flush_edge", 128'({cdb0_we, cdb1_we, src_ready}), 128'({2'b00, 3'b111}));
        repeat (4) begin
            cyc(3'b000, 1'b0);
            chk("flush_quiet", 128'({cdb0_we, cdb1_we}), 128'(0));
        end

        // random streams across pointer wrap
        do_rst();
        guard = 0;
        while ((acc[0] < 100 || acc[1] < 100 || acc[2] < 100) && guard < 4000) begin
            for (int s = 0; s < 3; s++) v[s] = (acc[s] < 100) && ($urandom_range(0, 2) != 0);
            cyc(v, 1'b0);
            guard++;
        end
        for (int s = 0; s < 3; s++) chk("wrap_accepted", 128'(acc[s] >= 100), 128'(1));
        repeat (6) cyc(3'b000, 1'b0);
        chk("drained", 128'(mq[0].size() + mq[1].size() + mq[2].size()), 128'(0));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
